sine_pwm_dac: RTL

Downstream consumer of the LUT sine generator's 16-bit sample stream. Converts each unsigned sample into one pulse-width-modulated period on a single output pin, which drives the board's RC-filtered audio/analogue output. Samples are accepted through a valid/ready handshake into a one-entry holding buffer so the producer can run ahead by one sample. Starvation is detected, flagged and counted rather than glitching the output.

---
 rtl/sine_pwm_dac_if.sv | 21 ++
 rtl/sine_pwm_dac.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sine_pwm_dac_if.sv
// Sample stream handshake between the sine LUT producer and the PWM DAC.
// The producer holds sample_in/sample_valid; the DAC answers with sample_ready.
interface sine_pwm_dac_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] sample_in;
   logic             sample_valid;
   logic             sample_ready;

   modport master (
      output sample_in,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_in,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/sine_pwm_dac.sv
// Sample-to-PWM converter: one PWM period of 2^PWM_BITS cycles per accepted sample,
// with a one-entry holding buffer and saturating starvation (underrun) counting.
module sine_pwm_dac #(
   parameter int WIDTH    = 16,
   parameter int PWM_BITS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   sine_pwm_dac_if.slave smp,
   output logic          pwm_out,
   output logic          period_start,
   output logic          underrun,
   output logic [15:0]   underrun_count
);

   localparam logic [PWM_BITS-1:0] K_LAST = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] K_ZERO = {PWM_BITS{1'b0}};
   localparam logic [PWM_BITS-1:0] K_ONE  = PWM_BITS'(1'b1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] k_q, k_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] buf_q, buf_d;
   logic                buf_full_q, buf_full_d;
   logic                ready_q, ready_d;
   logic                pwm_q, pwm_d;
   logic                pstart_q, pstart_d;
   logic                under_q, under_d;
   logic [15:0]         ucount_q, ucount_d;

   logic accept_s;
   logic load_s;
   logic boundary_s;
   logic underrun_s;
   logic run_s;
   logic unused_lsbs_s;

   // Only the duty field of each sample matters; the remaining bits are dropped here.
   assign unused_lsbs_s = ^smp.sample_in;

   // State and registered-output update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         k_q        <= K_ZERO;
         duty_q     <= K_ZERO;
         buf_q      <= K_ZERO;
         buf_full_q <= 1'b0;
         ready_q    <= 1'b0;
         pwm_q      <= 1'b0;
         pstart_q   <= 1'b0;
         under_q    <= 1'b0;
         ucount_q   <= 16'h0000;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         duty_q     <= duty_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         ready_q    <= ready_d;
         pwm_q      <= pwm_d;
         pstart_q   <= pstart_d;
         under_q    <= under_d;
         ucount_q   <= ucount_d;
      end
   end

   // Next-state logic: period counter, buffer handshake, duty reload and underrun count.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      load_s     = 1'b0;
      underrun_s = 1'b0;
      accept_s   = smp.sample_valid && ready_q;
      boundary_s = (state_q == ST_RUN) && (k_q == K_LAST);

      case (state_q)
         ST_IDLE: begin
            k_d = K_ZERO;
            if (buf_full_q && enable) begin
               state_d = ST_RUN;
               load_s  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            k_d = k_q + K_ONE;
            if (boundary_s) begin
               // enable only matters here, so a mid-period drop lets the period finish
               if (!enable) begin
                  state_d = ST_IDLE;
                  k_d     = K_ZERO;
               end else if (buf_full_q) begin
                  load_s = 1'b1;
               end else begin
                  underrun_s = 1'b1;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            k_d     = K_ZERO;
         end
      endcase

      if (load_s) begin
         duty_d = buf_q;
      end else begin
         duty_d = duty_q;
      end

      if (accept_s) begin
         buf_d = smp.sample_in[WIDTH-1 -: PWM_BITS];
      end else begin
         buf_d = buf_q;
      end

      // load and accept never coincide: ready is low whenever the buffer is loadable
      buf_full_d = (buf_full_q && !load_s) || accept_s;

      if (underrun_s && (ucount_q != 16'hFFFF)) begin
         ucount_d = ucount_q + 16'h0001;
      end else begin
         ucount_d = ucount_q;
      end
   end

   // Output decode from the next state so every output is a flop.
   always_comb begin
      run_s = (state_d == ST_RUN);
      if (run_s) begin
         pstart_d = (k_d == K_ZERO);
         pwm_d    = (k_d < duty_d);
         under_d  = underrun_s;
      end else begin
         pstart_d = 1'b0;
         pwm_d    = 1'b0;
         under_d  = 1'b0;
      end
      ready_d = !buf_full_d;
   end

   assign smp.sample_ready = ready_q;
   assign pwm_out          = pwm_q;
   assign period_start     = pstart_q;
   assign underrun         = under_q;
   assign underrun_count   = ucount_q;

endmodule
